alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the 16-bit ALU.
- Accepts one instruction word, reads two source registers from the synchronous-read register file, and builds operands A/B plus the 3-bit ALU opcode.
- Applies write-back bypass and presents A, B, op and rd to the ALU through a valid/ready handshake.
- The ALU result is registered downstream by the ALUOut register.

---
 rtl/proc_pkg.sv | 42 ++++
 rtl/operand_bypass.sv | 40 ++++
 rtl/alu_operand_stage.sv | 184 ++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the ALU issue path: datapath widths, ALU opcodes,
// instruction field positions, operand-stage FSM encoding and an immediate
// sign-extension helper.
package proc_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned REG_AW  = 3;
   localparam int unsigned IMM_W   = 6;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned INSTR_W = 16;

   // Instruction layout: [15] imm flag, [14:12] op, [11:9] rd, [8:6] rs,
   // [5:3] rt, [5:0] imm6 (rt and imm6 share the low bits).
   localparam int unsigned IMM_FLAG_BIT = 15;
   localparam int unsigned OP_LSB       = 12;
   localparam int unsigned RD_LSB       = 9;
   localparam int unsigned RS_LSB       = 6;
   localparam int unsigned RT_LSB       = 3;
   localparam int unsigned IMM_LSB      = 0;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_SHR  = 3'b010,
      ALU_SHL  = 3'b011,
      ALU_NAND = 3'b100,
      ALU_OR   = 3'b101,
      ALU_DIR  = 3'b110,
      ALU_SAR  = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/operand_bypass.sv
// Combinational operand select for one ALU source.
// Ports:
//   addr     - source register of this operand
//   imm_sel  - operand slot carries the immediate instead of a register
//   imm_val  - already sign-extended immediate
//   rf_data  - register file read data for addr
//   wb_*     - write-back port seen this cycle
//   hit_c    - write-back targets this live source register
//   value_c  - selected operand value (immediate / bypass / rf / zero for r0)
module operand_bypass
   import proc_pkg::*;
(
   input  logic [REG_AW-1:0] addr,
   input  logic              imm_sel,
   input  logic [DATA_W-1:0] imm_val,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              hit_c,
   output logic [DATA_W-1:0] value_c
);

   logic live;

   // r0 and the immediate slot never take a bypass
   assign live  = !imm_sel && (addr != '0);
   assign hit_c = live && wb_en && (wb_addr == addr);

   always_comb begin
      value_c = rf_data;
      if (imm_sel)
         value_c = imm_val;
      else if (hit_c)
         value_c = wb_data;
      else if (addr == '0)
         value_c = '0;
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the 16-bit ALU: captures an instruction, reads rs/rt
// from the synchronous register file, applies write-back bypass and holds
// A/B/op/rd for the ALU behind a valid/ready handshake.
// Optional: define ALU_OPERAND_STAGE_PERF_EN to add perf_issued/perf_stall
// saturating counters.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   in_valid/in_ready/in_instr  - instruction input handshake
//   rf_raddr_a/b, rf_rdata_a/b  - register file read port (1-cycle latency)
//   wb_en/wb_addr/wb_data       - register write-back snoop for bypass
//   out_valid/out_ready         - operand handshake to the ALU
//   alu_a/alu_b/alu_op/alu_rd   - registered operands, opcode and dest tag
module alu_operand_stage
   import proc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic [REG_AW-1:0]  rf_raddr_a,
   output logic [REG_AW-1:0]  rf_raddr_b,
   input  logic [DATA_W-1:0]  rf_rdata_a,
   input  logic [DATA_W-1:0]  rf_rdata_b,
   input  logic               wb_en,
   input  logic [REG_AW-1:0]  wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [OP_W-1:0]    alu_op,
   output logic [REG_AW-1:0]  alu_rd
`ifdef ALU_OPERAND_STAGE_PERF_EN
   ,
   output logic [15:0]        perf_issued,
   output logic [15:0]        perf_stall
`endif
);

   state_t state_q, state_d;
   logic   accept, fire;

   logic              imm_q;
   logic [OP_W-1:0]   op_q;
   logic [REG_AW-1:0] rd_q, rs_q, rt_q;
   logic [IMM_W-1:0]  imm6_q;

   logic              a_hit, b_hit;
   logic [DATA_W-1:0] a_val, b_val;

   // Address the RF straight from the incoming word so data lands in READ
   assign rf_raddr_a = in_instr[RS_LSB +: REG_AW];
   assign rf_raddr_b = in_instr[RT_LSB +: REG_AW];

   assign accept = in_valid && in_ready;
   assign fire   = out_valid && out_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // FSM next state and input-side ready
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_d = ST_READ;
         end
         ST_READ: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            in_ready = out_ready;
            if (out_ready)
               state_d = in_valid ? ST_READ : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   operand_bypass u_byp_a (
      .addr    (rs_q),
      .imm_sel (1'b0),
      .imm_val ('0),
      .rf_data (rf_rdata_a),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .hit_c   (a_hit),
      .value_c (a_val)
   );

   operand_bypass u_byp_b (
      .addr    (rt_q),
      .imm_sel (imm_q),
      .imm_val (sext_imm(imm6_q)),
      .rf_data (rf_rdata_b),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .hit_c   (b_hit),
      .value_c (b_val)
   );

   // Captured instruction fields
   always_ff @(posedge clk) begin
      if (rst) begin
         imm_q  <= 1'b0;
         op_q   <= '0;
         rd_q   <= '0;
         rs_q   <= '0;
         rt_q   <= '0;
         imm6_q <= '0;
      end else if (accept) begin
         imm_q  <= in_instr[IMM_FLAG_BIT];
         op_q   <= in_instr[OP_LSB +: OP_W];
         rd_q   <= in_instr[RD_LSB +: REG_AW];
         rs_q   <= in_instr[RS_LSB +: REG_AW];
         rt_q   <= in_instr[RT_LSB +: REG_AW];
         imm6_q <= in_instr[IMM_LSB +: IMM_W];
      end
   end

   // Operand registers toward the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= ALU_DIR;
         alu_rd    <= '0;
      end else begin
         case (state_q)
            ST_READ: begin
               out_valid <= 1'b1;
               alu_a     <= a_val;
               alu_b     <= b_val;
               alu_op    <= op_q;
               alu_rd    <= rd_q;
            end
            ST_HOLD: begin
               if (fire) begin
                  out_valid <= 1'b0;
               end else begin
                  // Retiring set is left alone; only a held set is refreshed
                  if (a_hit)
                     alu_a <= wb_data;
                  if (b_hit)
                     alu_b <= wb_data;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_OPERAND_STAGE_PERF_EN
   // Saturating issue / stall counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (fire && (perf_issued != 16'hFFFF))
            perf_issued <= perf_issued + 16'd1;
         if (out_valid && !out_ready && (perf_stall != 16'hFFFF))
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage with a small
// synchronous-read register file model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [2:0]  rf_raddr_a, rf_raddr_b;
   logic [15:0] rf_rdata_a, rf_rdata_b;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [2:0]  alu_rd;
`ifdef ALU_OPERAND_STAGE_PERF_EN
   logic [15:0] perf_issued, perf_stall;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] rf [8];

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_rdata_a (rf_rdata_a),
      .rf_rdata_b (rf_rdata_b),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_rd     (alu_rd)
`ifdef ALU_OPERAND_STAGE_PERF_EN
      ,
      .perf_issued (perf_issued),
      .perf_stall  (perf_stall)
`endif
   );

   // Register file: one-cycle synchronous read
   always @(posedge clk) begin
      rf_rdata_a <= rf[rf_raddr_a];
      rf_rdata_b <= rf[rf_raddr_b];
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one full cycle, ending at the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Accept an instruction from IDLE; returns in READ
   task automatic issue(input logic [15:0] instr);
      in_valid = 1'b1;
      in_instr = instr;
      step();
      in_valid = 1'b0;
   endtask

   // Complete the output handshake
   task automatic take();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
      wb_en   = en;
      wb_addr = a;
      wb_data = d;
   endtask

   initial begin
      rf[0] = 16'h1234; rf[1] = 16'd7;  rf[2] = 16'd54; rf[3] = 16'd5;
      rf[4] = 16'hAAAA; rf[5] = 16'h5555; rf[6] = 16'h0F0F; rf[7] = 16'hF0F0;
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
      wb(1'b0, 3'd0, 16'd0);
      @(negedge clk);
      step();
      check("rst_valid", 16'(out_valid), 16'd0);
      check("rst_op",    16'(alu_op),    16'd6);
      check("rst_a",     alu_a,          16'd0);
      check("rst_rd",    16'(alu_rd),    16'd0);
      rst = 1'b0;
      step();
      check("idle_ready", 16'(in_ready), 16'd1);

      // ADD r1,r2,r3
      in_instr = 16'h0298;
      #1;
      check("raddr_a", 16'(rf_raddr_a), 16'd2);
      check("raddr_b", 16'(rf_raddr_b), 16'd3);
      issue(16'h0298);
      check("read_ready", 16'(in_ready),  16'd0);
      check("read_valid", 16'(out_valid), 16'd0);
      step();
      check("add_valid", 16'(out_valid), 16'd1);
      check("add_a",     alu_a,          16'd54);
      check("add_b",     alu_b,          16'd5);
      check("add_op",    16'(alu_op),    16'd0);
      check("add_rd",    16'(alu_rd),    16'd1);
      take();
      check("add_done_valid", 16'(out_valid), 16'd0);
      check("add_done_ready", 16'(in_ready),  16'd1);

      // SUB r4,r2,#-1 with a write-back to r7 hitting only the imm slot
      issue(16'h98BF);
      wb(1'b1, 3'd7, 16'd99);
      step();
      wb(1'b0, 3'd0, 16'd0);
      check("subi_a",  alu_a,       16'd54);
      check("subi_b",  alu_b,       16'hFFFF);
      check("subi_op", 16'(alu_op), 16'd1);
      check("subi_rd", 16'(alu_rd), 16'd4);
      take();

      // ADD r5,r3,#-32
      issue(16'h8AE0);
      step();
      check("addi_a",  alu_a,       16'd5);
      check("addi_b",  alu_b,       16'hFFE0);
      check("addi_rd", 16'(alu_rd), 16'd5);
      take();

      // DIR r2,r0,r2 with a write-back to r0 (must be ignored)
      issue(16'h6410);
      wb(1'b1, 3'd0, 16'd99);
      step();
      wb(1'b0, 3'd0, 16'd0);
      check("r0_a",  alu_a,       16'd0);
      check("r0_b",  alu_b,       16'd54);
      check("r0_op", 16'(alu_op), 16'd6);
      take();

      // OR r3,r1,r0
      issue(16'h5640);
      step();
      check("rt0_a",  alu_a,       16'd7);
      check("rt0_b",  alu_b,       16'd0);
      check("rt0_op", 16'(alu_op), 16'd5);
      check("rt0_rd", 16'(alu_rd), 16'd3);
      take();

      // Bypass during READ
      issue(16'h0298);
      wb(1'b1, 3'd2, 16'd99);
      step();
      wb(1'b0, 3'd0, 16'd0);
      check("byp_read_a", alu_a, 16'd99);
      check("byp_read_b", alu_b, 16'd5);
      take();

      // wb_addr == rs == rt
      issue(16'h0290);
      wb(1'b1, 3'd2, 16'd99);
      step();
      wb(1'b0, 3'd0, 16'd0);
      check("byp_both_a", alu_a, 16'd99);
      check("byp_both_b", alu_b, 16'd99);
      take();

      // Bypass during HOLD, then wb coinciding with the handshake
      issue(16'h0298);
      step();
      wb(1'b1, 3'd2, 16'd99);
      step();
      wb(1'b0, 3'd0, 16'd0);
      check("byp_hold_valid", 16'(out_valid), 16'd1);
      check("byp_hold_a",     alu_a,          16'd99);
      check("byp_hold_b",     alu_b,          16'd5);
      wb(1'b1, 3'd3, 16'd77);
      take();
      wb(1'b0, 3'd0, 16'd0);
      check("byp_fire_valid", 16'(out_valid), 16'd0);
      check("byp_fire_b",     alu_b,          16'd5);

      // Back-to-back with a 3-cycle stall
      issue(16'h0298);
      step();
      in_valid = 1'b1;
      in_instr = 16'h98BF;
      for (int i = 0; i < 3; i++) begin
         check("stall_ready", 16'(in_ready),  16'd0);
         check("stall_valid", 16'(out_valid), 16'd1);
         check("stall_a",     alu_a,          16'd54);
         check("stall_b",     alu_b,          16'd5);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("b2b_ready", 16'(in_ready), 16'd1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_read_valid", 16'(out_valid), 16'd0);
      check("b2b_read_ready", 16'(in_ready),  16'd0);
      step();
      check("b2b_valid", 16'(out_valid), 16'd1);
      check("b2b_a",     alu_a,          16'd54);
      check("b2b_b",     alu_b,          16'hFFFF);
      check("b2b_op",    16'(alu_op),    16'd1);
      check("b2b_rd",    16'(alu_rd),    16'd4);
      take();

      // Reset while in READ
      issue(16'h0298);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_read_valid", 16'(out_valid), 16'd0);
      check("rst_read_ready", 16'(in_ready),  16'd1);
      check("rst_read_a",     alu_a,          16'd0);
      check("rst_read_op",    16'(alu_op),    16'd6);
      step();
      check("rst_read_discard", 16'(out_valid), 16'd0);

      // Reset while in HOLD
      issue(16'h0298);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_hold_valid", 16'(out_valid), 16'd0);
      check("rst_hold_ready", 16'(in_ready),  16'd1);
      check("rst_hold_a",     alu_a,          16'd0);
      check("rst_hold_b",     alu_b,          16'd0);
      check("rst_hold_rd",    16'(alu_rd),    16'd0);
      check("rst_hold_op",    16'(alu_op),    16'd6);
      step();
      check("rst_hold_discard", 16'(out_valid), 16'd0);

`ifdef ALU_OPERAND_STAGE_PERF_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("perf_rst_issued", perf_issued, 16'd0);
      check("perf_rst_stall",  perf_stall,  16'd0);
      issue(16'h0298);
      step();
      for (int i = 0; i < 4; i++) step();
      take();
      issue(16'h8AE0);
      step();
      take();
      issue(16'h6410);
      step();
      take();
      check("perf_issued", perf_issued, 16'd3);
      check("perf_stall",  perf_stall,  16'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
